// File: rtl/demod_segment_corr.sv
// Per-segment correlator: multiplies SEG_LEN received samples by the reference waveform,
// sums them and decodes the sign of the sum into one bit delivered over valid/ready.
module demod_segment_corr #(
  parameter int DATA_W  = 32,
  parameter int SEG_LEN = 16,
  parameter int CNT_W   = 4,
  parameter int ACC_W   = 68
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [CNT_W-1:0]  ref_idx,
  input  logic [DATA_W-1:0] ref_sample,
  output logic              bit_out,
  output logic [ACC_W-1:0]  corr_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic [15:0]       sym_count
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PROD_W-1:0]  prod_r;
  logic               prod_v_r;
  logic [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [PROD_W-1:0]  samp_ext_s, ref_ext_s, prod_nxt_s;
  logic               accept_s;
  logic [CNT_W-1:0]   ref_idx_nxt_s;
  logic               bit_out_nxt_s, bit_valid_nxt_s;
  logic [ACC_W-1:0]   corr_nxt_s;
  logic [15:0]        sym_nxt_s;

  // Operands are sign-extended to full product width so the low PROD_W bits are exact.
  assign samp_ext_s = {{DATA_W{sample_in[DATA_W-1]}}, sample_in};
  assign ref_ext_s  = {{DATA_W{ref_sample[DATA_W-1]}}, ref_sample};
  assign prod_nxt_s = samp_ext_s * ref_ext_s;
  assign prod_ext_s = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  assign accept_s   = sample_valid && sample_ready;

  // Next-state, accumulator and output-register decode.
  always_comb begin
    state_nxt_s     = state_r;
    ref_idx_nxt_s   = ref_idx;
    bit_out_nxt_s   = bit_out;
    corr_nxt_s      = corr_out;
    bit_valid_nxt_s = bit_valid;
    sym_nxt_s       = sym_count;
    if (prod_v_r) begin
      sum_s = acc_r + prod_ext_s;
    end else begin
      sum_s = acc_r;
    end
    acc_nxt_s = sum_s;
    case (state_r)
      ST_ACCUM: begin
        if (accept_s) begin
          if (ref_idx == CNT_W'(SEG_LEN - 1)) begin
            ref_idx_nxt_s = {CNT_W{1'b0}};
            state_nxt_s   = ST_FLUSH;
          end else begin
            ref_idx_nxt_s = ref_idx + CNT_W'(1);
          end
        end else begin
          ref_idx_nxt_s = ref_idx;
        end
      end
      ST_FLUSH: begin
        corr_nxt_s      = sum_s;
        bit_out_nxt_s   = sum_s[ACC_W-1];
        bit_valid_nxt_s = 1'b1;
        acc_nxt_s       = {ACC_W{1'b0}};
        state_nxt_s     = ST_OUT;
      end
      ST_OUT: begin
        if (bit_ready) begin
          bit_valid_nxt_s = 1'b0;
          sym_nxt_s       = sym_count + 16'd1;
          state_nxt_s     = ST_ACCUM;
        end else begin
          bit_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = ST_ACCUM;
        ref_idx_nxt_s   = {CNT_W{1'b0}};
        acc_nxt_s       = {ACC_W{1'b0}};
        bit_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_ACCUM;
      sample_ready <= 1'b1;
      ref_idx      <= {CNT_W{1'b0}};
      prod_r       <= {PROD_W{1'b0}};
      prod_v_r     <= 1'b0;
      acc_r        <= {ACC_W{1'b0}};
      bit_out      <= 1'b0;
      corr_out     <= {ACC_W{1'b0}};
      bit_valid    <= 1'b0;
      sym_count    <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      sample_ready <= (state_nxt_s == ST_ACCUM);
      ref_idx      <= ref_idx_nxt_s;
      prod_r       <= accept_s ? prod_nxt_s : prod_r;
      prod_v_r     <= accept_s;
      acc_r        <= acc_nxt_s;
      bit_out      <= bit_out_nxt_s;
      corr_out     <= corr_nxt_s;
      bit_valid    <= bit_valid_nxt_s;
      sym_count    <= sym_nxt_s;
    end
  end

endmodule

// File: tb/tb_demod_segment_corr.sv
// Scoreboard bench for demod_segment_corr with SEG_LEN=4 and a bench-owned reference table.
module tb_demod_segment_corr;

  localparam int DW = 32;
  localparam int SL = 4;
  localparam int CW = 2;
  localparam int AW = 66;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [CW-1:0] ref_idx;
  logic [DW-1:0] ref_sample;
  logic          bit_out;
  logic [AW-1:0] corr_out;
  logic          bit_valid;
  logic          bit_ready;
  logic [15:0]   sym_count;

  logic [DW-1:0] ref_tab [SL];

  typedef struct packed {
    logic          b;
    logic [AW-1:0] c;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  demod_segment_corr #(.DATA_W(DW), .SEG_LEN(SL), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .ref_idx(ref_idx), .ref_sample(ref_sample),
    .bit_out(bit_out), .corr_out(corr_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sym_count(sym_count)
  );

  always #5 clk = ~clk;
  assign ref_sample = ref_tab[ref_idx];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every delivered bit is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bit_valid && bit_ready) begin
      chk("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("bit_out", 128'(bit_out), 128'(mon_e.b));
        chk("corr_out", 128'(corr_out), 128'(mon_e.c));
      end
    end
  end

  task automatic send_sample(input logic [DW-1:0] v);
    int guard = 0;
    sample_in    = v;
    sample_valid = 1'b1;
    while (!sample_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 128'(sample_ready), 128'd1);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d,
                          input logic eb, input logic [AW-1:0] ec);
    exp_t e;
    e.b = eb;
    e.c = ec;
    sb_q.push_back(e);
    send_sample(a);
    send_sample(b);
    send_sample(c);
    send_sample(d);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb_q.size() != 0 || bit_valid) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("drain_timeout", 128'(sb_q.size()), 128'd0);
  endtask

  logic [AW-1:0] pos_c, neg_c, big_c;
  int            pat [7];
  logic [DW-1:0] smp [4];
  int            k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pos_c = 66'sd40000;
    neg_c = -66'sd40000;
    big_c = 66'h1_0000_0000_0000_0000;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = 32'd0;
    bit_ready = 1'b1;
    ref_tab[0] = 32'sd100;  ref_tab[1] = -32'sd100;
    ref_tab[2] = 32'sd100;  ref_tab[3] = -32'sd100;
    #12;
    chk("rst_ref_idx", 128'(ref_idx), 128'd0);
    chk("rst_bit_out", 128'(bit_out), 128'd0);
    chk("rst_corr_out", 128'(corr_out), 128'd0);
    chk("rst_bit_valid", 128'(bit_valid), 128'd0);
    chk("rst_sym_count", 128'(sym_count), 128'd0);
    chk("rst_sample_ready", 128'(sample_ready), 128'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: matched waveform, latency check
    send_sym(32'sd100, -32'sd100, 32'sd100, -32'sd100, 1'b0, pos_c);
    chk("t1_flush_valid", 128'(bit_valid), 128'd0);
    chk("t1_flush_ready", 128'(sample_ready), 128'd0);
    @(posedge clk); #1;
    chk("t1_lat_valid", 128'(bit_valid), 128'd1);
    @(posedge clk); #1;
    chk("t1_sym_count", 128'(sym_count), 128'd1);
    chk("t1_ready_back", 128'(sample_ready), 128'd1);

    // Test 2: inverted waveform
    send_sym(-32'sd100, 32'sd100, -32'sd100, 32'sd100, 1'b1, neg_c);
    drain();
    // Test 3: all zeros (tie)
    send_sym(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 66'd0);
    drain();

    // Test 4: sink back-pressure for 5 cycles
    bit_ready = 1'b0;
    send_sym(-32'sd100, 32'sd100, -32'sd100, 32'sd100, 1'b1, neg_c);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_in = 32'sd77;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 128'(bit_valid), 128'd1);
      chk("t4_hold_bit", 128'(bit_out), 128'd1);
      chk("t4_hold_corr", 128'(corr_out), 128'(neg_c));
      chk("t4_hold_ready", 128'(sample_ready), 128'd0);
      chk("t4_hold_ref_idx", 128'(ref_idx), 128'd0);
      chk("t4_hold_sym", 128'(sym_count), 128'd3);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    bit_ready = 1'b1;
    send_sym(32'sd100, -32'sd100, 32'sd100, -32'sd100, 1'b0, pos_c);
    drain();

    // Test 5: gappy sample_valid
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    smp[0] = 32'sd100; smp[1] = -32'sd100; smp[2] = 32'sd100; smp[3] = -32'sd100;
    sb_q.push_back('{b: 1'b0, c: pos_c});
    k = 0;
    for (int i = 0; i < 7; i++) begin
      sample_valid = (pat[i] != 0);
      if (pat[i] != 0) sample_in = smp[k];
      else sample_in = 32'sd999;
      @(posedge clk); #1;
      if (pat[i] != 0) k++;
      chk("t5_ref_idx", 128'(ref_idx), 128'(k % 4));
    end
    sample_valid = 1'b0;
    drain();

    // Test 6: reset mid-symbol, then fresh symbol and extreme operands
    send_sample(32'sd100);
    send_sample(-32'sd100);
    reset = 1'b1;
    #1;
    chk("t6_ref_idx", 128'(ref_idx), 128'd0);
    chk("t6_bit_valid", 128'(bit_valid), 128'd0);
    chk("t6_corr_out", 128'(corr_out), 128'd0);
    chk("t6_bit_out", 128'(bit_out), 128'd0);
    chk("t6_sym_count", 128'(sym_count), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_sym(32'sd100, -32'sd100, 32'sd100, -32'sd100, 1'b0, pos_c);
    drain();
    for (int i = 0; i < SL; i++) ref_tab[i] = 32'h8000_0000;
    send_sym(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, big_c);
    drain();
    chk("t6_sym_after", 128'(sym_count), 128'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
